// File: rtl/ethernet_pkg.sv
// ethernet_pkg
// Shared types and constants for the Ethernet receive path.
//   - wr_state_e : write-side FSM states (W_IDLE, W_ACTIVE, W_OVERFLOW)
//   - rd_state_e : read-side FSM states (R_IDLE, R_STREAM)
//   - ETHERNET_MAX_FRAME_BYTES : largest frame, MAC destination through FCS
//   - ETHERNET_LEN_W : width of a frame length field
package ethernet_pkg;

    localparam int ETHERNET_MAX_FRAME_BYTES = 1518;
    localparam int ETHERNET_LEN_W           = 11;

    typedef enum logic [1:0] {
        W_IDLE     = 2'd0,
        W_ACTIVE   = 2'd1,
        W_OVERFLOW = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ethernet_receive_descriptor_fifo.sv
// ethernet_receive_descriptor_fifo
// Synchronous FIFO of committed frame lengths, FRAME_SLOTS deep (power of two, >= 2).
// Ports:
//   clock, reset   : clock and asynchronous active-high reset
//   push_i         : write push_len_i (ignored when full)
//   push_len_i     : frame length to store
//   pop_i          : drop the head entry (ignored when empty)
//   pop_len_o      : head entry, valid while !empty_o
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored entries
module ethernet_receive_descriptor_fifo
    import ethernet_pkg::*;
#(
    parameter int FRAME_SLOTS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [ETHERNET_LEN_W-1:0]     push_len_i,
    input  logic                          pop_i,
    output logic [ETHERNET_LEN_W-1:0]     pop_len_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FRAME_SLOTS):0]  count_o
);
    localparam int IW = $clog2(FRAME_SLOTS);

    logic [ETHERNET_LEN_W-1:0] len_mem [FRAME_SLOTS];
    logic [IW:0]               wr_idx_q;
    logic [IW:0]               rd_idx_q;
    logic                      push_ok;
    logic                      pop_ok;

    assign count_o   = wr_idx_q - rd_idx_q;
    assign full_o    = (count_o == (IW+1)'(FRAME_SLOTS));
    assign empty_o   = (count_o == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign pop_len_o = len_mem[rd_idx_q[IW-1:0]];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            len_mem[wr_idx_q[IW-1:0]] <= push_len_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (push_ok) wr_idx_q <= wr_idx_q + (IW+1)'(1);
            if (pop_ok)  rd_idx_q <= rd_idx_q + (IW+1)'(1);
        end
    end

endmodule

// File: rtl/ethernet_receive_buffer.sv
// ethernet_receive_buffer
// Per-slot receive frame buffer behind the Ethernet packet parser. Bytes of the
// current frame are written speculatively into a byte RAM; a good verdict commits
// them (length pushed to a descriptor FIFO), a bad verdict / overflow rolls the
// write pointer back. Committed frames are replayed over a valid/ready stream.
// Optional feature macro: ETHERNET_RECEIVE_BUFFER_STATS_EN (dropped-frame counter;
// when undefined dropped_count is tied to 0).
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   packet_data/_valid           : byte stream from the parser
//   good_packet/bad_packet       : end-of-frame verdict pulses
//   recieve_slot_enable          : registered "a whole new frame fits" flag
//   read_data/_valid/_ready      : replay stream to the fabric
//   read_last, read_length       : last-byte marker and frame length of the byte shown
//   frames_pending               : descriptor FIFO occupancy
//   dropped_count                : saturating discarded-frame count
module ethernet_receive_buffer
    import ethernet_pkg::*;
#(
    parameter int DEPTH           = 2048,
    parameter int MAX_FRAME_BYTES = ETHERNET_MAX_FRAME_BYTES,
    parameter int FRAME_SLOTS     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    packet_data,
    input  logic                          packet_data_valid,
    input  logic                          good_packet,
    input  logic                          bad_packet,
    output logic                          recieve_slot_enable,
    output logic [7:0]                    read_data,
    output logic                          read_data_valid,
    input  logic                          read_data_ready,
    output logic                          read_last,
    output logic [10:0]                   read_length,
    output logic [$clog2(FRAME_SLOTS):0]  frames_pending,
    output logic [15:0]                   dropped_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = ETHERNET_LEN_W;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_P   = PW'(MAX_FRAME_BYTES);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_BYTES);

    // ---------------- write side ----------------
    wr_state_e       w_state_q, w_state_d;
    logic [PW-1:0]   wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic [LW-1:0]   frame_len_q;
    logic [PW-1:0]   used, free;
    logic            ram_full, len_max, byte_ok, byte_rej, verdict, keep;
    logic            ram_we, wr_commit, wr_discard;
    logic            rse_q;

    logic            desc_full, desc_empty, desc_pop;
    logic [LW-1:0]   desc_len;

    // Uncommitted bytes count as used, so the writer can never overrun unread data.
    assign used     = wr_ptr_q - rd_ptr_q;
    assign free     = DEPTH_P - used;
    assign ram_full = (used == DEPTH_P);
    assign len_max  = (w_state_q == W_ACTIVE) && (frame_len_q == MAX_LEN);
    assign byte_ok  = packet_data_valid && (w_state_q != W_OVERFLOW) && !ram_full && !len_max;
    assign byte_rej = packet_data_valid && (w_state_q != W_OVERFLOW) && !byte_ok;
    assign verdict  = good_packet || bad_packet;
    // bad wins over good; a byte rejected in the verdict cycle spoils the frame
    assign keep     = good_packet && !bad_packet && !desc_full && !byte_rej;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) w_state_q <= W_IDLE;
        else       w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:     if (byte_ok) w_state_d = W_ACTIVE;
                        else if (byte_rej) w_state_d = W_OVERFLOW;
            W_ACTIVE:   if (verdict) w_state_d = W_IDLE;
                        else if (byte_rej) w_state_d = W_OVERFLOW;
            W_OVERFLOW: if (verdict) w_state_d = W_IDLE;
            default:    w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        ram_we     = 1'b0;
        wr_commit  = 1'b0;
        wr_discard = 1'b0;
        case (w_state_q)
            W_IDLE:     ram_we = byte_ok;   // verdicts without a frame are ignored
            W_ACTIVE: begin
                ram_we = byte_ok;
                if (verdict) begin
                    wr_commit  = keep;
                    wr_discard = !keep;
                end
            end
            W_OVERFLOW: wr_discard = verdict;
            default:    ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            frame_len_q  <= '0;
            rse_q        <= 1'b0;
        end else begin
            if (wr_discard)  wr_ptr_q <= commit_ptr_q;
            else if (ram_we) wr_ptr_q <= wr_ptr_q + PW'(1);
            // a byte landing in the verdict cycle belongs to the committed frame
            if (wr_commit)   commit_ptr_q <= wr_ptr_q + PW'(ram_we);
            if (ram_we)      frame_len_q <= (w_state_q == W_IDLE) ? LW'(1) : frame_len_q + LW'(1);
            rse_q <= (w_state_q == W_IDLE) && (free >= MAX_P) && !desc_full;
        end
    end

    assign recieve_slot_enable = rse_q;

`ifdef ETHERNET_RECEIVE_BUFFER_STATS_EN
    logic [15:0] dropped_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                      dropped_q <= '0;
        else if (wr_discard && dropped_q != 16'hFFFF)   dropped_q <= dropped_q + 16'd1;
    end
    assign dropped_count = dropped_q;
`else
    assign dropped_count = '0;
`endif

    ethernet_receive_descriptor_fifo #(.FRAME_SLOTS(FRAME_SLOTS)) u_desc_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (wr_commit),
        .push_len_i (frame_len_q + LW'(ram_we)),
        .pop_i      (desc_pop),
        .pop_len_o  (desc_len),
        .full_o     (desc_full),
        .empty_o    (desc_empty),
        .count_o    (frames_pending)
    );

    // ---------------- byte RAM (simple dual port, registered read) ----------------
    logic [7:0] byte_ram [DEPTH];
    logic [7:0] ram_data_q;
    logic       rd_issue;

    always_ff @(posedge clock) begin
        if (ram_we)   byte_ram[wr_ptr_q[AW-1:0]] <= packet_data;
        if (rd_issue) ram_data_q <= byte_ram[rd_ptr_q[AW-1:0]];
    end

    // ---------------- read side ----------------
    rd_state_e      r_state_q, r_state_d;
    logic [LW-1:0]  rd_rem_q, rd_len_q;
    logic           ram_vld_q, ram_last_q;
    logic [LW-1:0]  ram_len_q;
    logic [7:0]     out_data_q, skid_data_q;
    logic           out_vld_q, out_last_q, skid_vld_q, skid_last_q;
    logic [LW-1:0]  out_len_q, skid_len_q;
    logic           out_pop, can_issue;
    logic [1:0]     occ;

    // Issue only if the byte is certain to find room in the two-entry output
    // buffer when it leaves the RAM register, even if the fabric stalls.
    assign out_pop   = out_vld_q && read_data_ready;
    assign occ       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q);
    assign can_issue = (occ <= (2'd1 + 2'(out_pop)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state_q <= R_IDLE;
        else       r_state_q <= r_state_d;
    end

    // The next descriptor is fetched as soon as the current frame's last byte has
    // been issued, giving a single bubble between frames; the length travels with
    // each byte so read_length stays correct for bytes still buffered.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:   if (!desc_empty) r_state_d = R_STREAM;
            R_STREAM: if (rd_issue && rd_rem_q == LW'(1)) r_state_d = R_IDLE;
            default:  r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        desc_pop = (r_state_q == R_IDLE) && !desc_empty;
        rd_issue = (r_state_q == R_STREAM) && can_issue;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            rd_rem_q    <= '0;
            rd_len_q    <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            ram_len_q   <= '0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_len_q   <= '0;
            skid_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_len_q  <= '0;
        end else begin
            if (desc_pop) begin
                rd_rem_q <= desc_len;
                rd_len_q <= desc_len;
            end else if (rd_issue) begin
                rd_rem_q <= rd_rem_q - LW'(1);
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            ram_vld_q <= rd_issue;
            if (rd_issue) begin
                ram_last_q <= (rd_rem_q == LW'(1));
                ram_len_q  <= rd_len_q;
            end
            if (!out_vld_q || out_pop) begin
                if (skid_vld_q) begin
                    out_data_q <= skid_data_q;
                    out_last_q <= skid_last_q;
                    out_len_q  <= skid_len_q;
                    out_vld_q  <= 1'b1;
                    skid_vld_q <= ram_vld_q;
                    if (ram_vld_q) begin
                        skid_data_q <= ram_data_q;
                        skid_last_q <= ram_last_q;
                        skid_len_q  <= ram_len_q;
                    end
                end else begin
                    out_vld_q <= ram_vld_q;
                    if (ram_vld_q) begin
                        out_data_q <= ram_data_q;
                        out_last_q <= ram_last_q;
                        out_len_q  <= ram_len_q;
                    end
                end
            end else if (ram_vld_q) begin
                skid_data_q <= ram_data_q;
                skid_last_q <= ram_last_q;
                skid_len_q  <= ram_len_q;
                skid_vld_q  <= 1'b1;
            end
        end
    end

    assign read_data       = out_data_q;
    assign read_data_valid = out_vld_q;
    assign read_last       = out_last_q;
    assign read_length     = out_len_q;

endmodule

// File: tb/tb_ethernet_receive_buffer.sv
// Self-checking bench for ethernet_receive_buffer. A reference model holds the
// frames expected on the read port as byte/length queues; a monitor compares
// every accepted output byte against it.
module tb_ethernet_receive_buffer;
    localparam int MAXB = 1518;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  packet_data = '0;
    logic        packet_data_valid = 1'b0;
    logic        good_packet = 1'b0;
    logic        bad_packet = 1'b0;
    logic        recieve_slot_enable;
    logic [7:0]  read_data;
    logic        read_data_valid;
    logic        read_data_ready = 1'b0;
    logic        read_last;
    logic [10:0] read_length;
    logic [2:0]  frames_pending;
    logic [15:0] dropped_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 1;        // 0 low, 1 high, 2 toggle, 3 random
    int model_drops = 0;
    int mon_pos = 0;
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];

    ethernet_receive_buffer dut (
        .clock               (clock),
        .reset               (reset),
        .packet_data         (packet_data),
        .packet_data_valid   (packet_data_valid),
        .good_packet         (good_packet),
        .bad_packet          (bad_packet),
        .recieve_slot_enable (recieve_slot_enable),
        .read_data           (read_data),
        .read_data_valid     (read_data_valid),
        .read_data_ready     (read_data_ready),
        .read_last           (read_last),
        .read_length         (read_length),
        .frames_pending      (frames_pending),
        .dropped_count       (dropped_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_dropped();
`ifdef ETHERNET_RECEIVE_BUFFER_STATS_EN
        return (model_drops > 65535) ? 32'hFFFF : 32'(model_drops);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fabric ready driver.
    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       read_data_ready = 1'b0;
            1:       read_data_ready = 1'b1;
            2:       read_data_ready = ~read_data_ready;
            default: read_data_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: every accepted byte must be the next expected one.
    always @(negedge clock) begin
        if (!reset && read_data_valid && read_data_ready) begin
            if (exp_bytes.size() == 0) begin
                check("unexpected_byte_valid", 32'(read_data_valid), 32'd0);
            end else begin
                logic [7:0] eb;
                int el;
                eb = exp_bytes.pop_front();
                el = exp_lens[0];
                check("rd_data", 32'(read_data), 32'(eb));
                check("rd_length", 32'(read_length), 32'(el));
                check("rd_last", 32'(read_last), 32'(mon_pos == el - 1));
                $display("byte %0d/%0d data=%02h last=%0b", mon_pos + 1, el, read_data, read_last);
                if (mon_pos == el - 1) begin
                    mon_pos = 0;
                    void'(exp_lens.pop_front());
                end else begin
                    mon_pos++;
                end
            end
        end
    end

    // Drive one frame and update the model: kept only for a lone good verdict,
    // a legal length and room in the descriptor store (room supplied by caller).
    task automatic send_frame(input int n, input bit pattern, input bit g, input bit b,
                              input bit with_last, input bit room);
        logic [7:0] bytes[$];
        for (int i = 0; i < n; i++)
            bytes.push_back(pattern ? 8'(i) : 8'($urandom_range(0, 255)));
        for (int i = 0; i < n; i++) begin
            packet_data = bytes[i];
            packet_data_valid = 1'b1;
            if (with_last && i == n - 1) begin
                good_packet = g;
                bad_packet  = b;
            end
            tick();
        end
        packet_data_valid = 1'b0;
        if (!with_last) begin
            good_packet = g;
            bad_packet  = b;
            tick();
        end
        good_packet = 1'b0;
        bad_packet  = 1'b0;
        if (g && !b && n <= MAXB && room) begin
            foreach (bytes[i]) exp_bytes.push_back(bytes[i]);
            exp_lens.push_back(n);
            $display("frame len=%0d committed", n);
        end else begin
            model_drops++;
            $display("frame len=%0d dropped", n);
        end
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while ((exp_bytes.size() != 0 || read_data_valid) && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_drain"}, 32'(exp_bytes.size()), 32'd0);
    endtask

    initial begin
        // ---- reset ----
        repeat (3) @(posedge clock);
        #1;
        check("rst_rse", 32'(recieve_slot_enable), 0);
        check("rst_valid", 32'(read_data_valid), 0);
        check("rst_pending", 32'(frames_pending), 0);
        check("rst_dropped", 32'(dropped_count), 0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_rse_before_edge", 32'(recieve_slot_enable), 0);
        @(negedge clock);
        check("rel_rse_after_edge", 32'(recieve_slot_enable), 1);

        // ---- good frame 0x00..0x3F, latency ----
        send_frame(64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        check("good_pending", 32'(frames_pending), 1);
        check("lat_c1", 32'(read_data_valid), 0);
        @(negedge clock);
        check("lat_c2", 32'(read_data_valid), 0);
        @(negedge clock);
        check("lat_c3_pre", 32'(read_data_valid), 0);
        @(negedge clock);
        check("lat_first_valid", 32'(read_data_valid), 1);
        wait_drain("good");
        check("good_pending_end", 32'(frames_pending), 0);

        // ---- bad then good ----
        send_frame(100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(60, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("badgood");
        check("badgood_dropped", 32'(dropped_count), exp_dropped());

        // ---- oversize ----
        send_frame(1600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        check("over_pending", 32'(frames_pending), 0);
        check("over_dropped", 32'(dropped_count), exp_dropped());
        check("over_rse", 32'(recieve_slot_enable), 1);
        wait_drain("over");

        // ---- verdict collisions with toggling ready ----
        ready_mode = 2;
        send_frame(40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_drain("byte_good");
        send_frame(30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(25, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_drain("good_bad");
        check("collide_dropped", 32'(dropped_count), exp_dropped());

        // ---- random frames, random ready ----
        ready_mode = 3;
        for (int k = 0; k < 6; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            send_frame($urandom_range(2, 120), 1'b0, kind != 1, kind != 0,
                       1'($urandom_range(0, 1)), 1'b1);
            wait_drain("rand");
        end
        check("rand_dropped", 32'(dropped_count), exp_dropped());

        // ---- descriptor store full (reader holds the first frame's descriptor,
        //      so the FIFO fills on the fifth frame) ----
        ready_mode = 0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            send_frame(64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            repeat (3) @(negedge clock);
            check("full_pending", 32'(frames_pending), 32'(i - 1));
        end
        check("full_rse", 32'(recieve_slot_enable), 0);
        send_frame(64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check("full_extra_pending", 32'(frames_pending), 4);
        check("full_extra_dropped", 32'(dropped_count), exp_dropped());
        ready_mode = 1;
        begin
            int cyc = 0;
            while (frames_pending == 3'd4 && cyc < 500) begin
                @(negedge clock);
                cyc++;
            end
        end
        repeat (3) @(negedge clock);
        check("full_rse_back", 32'(recieve_slot_enable), 1);
        wait_drain("full");
        check("full_pending_end", 32'(frames_pending), 0);

        // ---- reset mid-frame and mid-readout ----
        ready_mode = 0;
        tick();
        send_frame(64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        check("mid_readout_valid", 32'(read_data_valid), 1);
        for (int i = 0; i < 30; i++) begin
            packet_data = 8'($urandom_range(0, 255));
            packet_data_valid = 1'b1;
            tick();
        end
        reset = 1'b1;
        packet_data_valid = 1'b0;
        #1;
        check("mid_rst_rse", 32'(recieve_slot_enable), 0);
        check("mid_rst_data", 32'(read_data), 0);
        check("mid_rst_valid", 32'(read_data_valid), 0);
        check("mid_rst_last", 32'(read_last), 0);
        check("mid_rst_length", 32'(read_length), 0);
        check("mid_rst_pending", 32'(frames_pending), 0);
        check("mid_rst_dropped", 32'(dropped_count), 0);
        exp_bytes.delete();
        exp_lens.delete();
        mon_pos = 0;
        model_drops = 0;
        repeat (2) tick();
        reset = 1'b0;
        ready_mode = 1;
        repeat (3) @(negedge clock);
        check("post_rst_pending", 32'(frames_pending), 0);
        check("post_rst_valid", 32'(read_data_valid), 0);
        check("post_rst_rse", 32'(recieve_slot_enable), 1);
        send_frame(50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("post_rst");
        check("post_rst_dropped", 32'(dropped_count), exp_dropped());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
